abc_vector_sequencer: RTL

Upstream stimulus stage for the three-input combinational block (inputs A/B/C, outputs X/Y/Z). On a start request, it walks all eight A/B/C input combinations. Each vector is held for a programmable dwell time. At the end of each dwell it samples X/Y/Z and compares them against the golden function X=A, Y=B, Z=A|B, counting mismatches. It turns the hand-written stimulus sequence into a self-running, self-checking hardware stage.

---
 rtl/abc_seq_pkg.sv | 20 ++
 rtl/abc_dwell_timer.sv | 29 ++
 rtl/abc_vector_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/abc_seq_pkg.sv
// Shared types and constants for the A/B/C vector sequencer: FSM states,
// vector count and the golden X/Y/Z function of the block under drive.
package abc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VEC = 8;
    localparam int VEC_W   = 3;

    // C is a don't-care of the golden function; it is folded in as a zero term
    // so the argument list stays symmetric with the stimulus vector.
    function automatic logic [2:0] exp_xyz(input logic a, input logic b, input logic c);
        return {a, b, a | b} | {3{c & 1'b0}};
    endfunction

endpackage

// File: rtl/abc_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last cycle of
// each dwell with a combinational terminal-count output.
module abc_dwell_timer #(
    parameter int DWELL = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (enable) begin
            count_reg <= (count_reg == LAST) ? 8'd0 : count_reg + 8'd1;
        end
    end

    assign terminal = enable && (count_reg == LAST);

endmodule

// File: rtl/abc_vector_sequencer.sv
// Walks all eight A/B/C vectors, holds each for DWELL cycles and counts X/Y/Z
// mismatches against the golden function. ABC_SEQ_FAIL_CAPTURE_EN adds first-fail capture.
module abc_vector_sequencer
    import abc_seq_pkg::*;
#(
    parameter int DWELL = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic             X_in,
    input  logic             Y_in,
    input  logic             Z_in,
    output logic             A_out,
    output logic             B_out,
    output logic             C_out,
    output logic [2:0]       vec_idx_out,
    output logic             busy_out,
    output logic             done_out,
`ifdef ABC_SEQ_FAIL_CAPTURE_EN
    output logic             first_fail_vld_out,
    output logic [5:0]       first_fail_out,
`endif
    output logic [CNT_W-1:0] err_count_out
);

    localparam logic [CNT_W-1:0] ERR_MAX  = '1;
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [VEC_W-1:0]   vec_idx_reg;
    logic [CNT_W-1:0]   err_count_reg;
    logic               in_run;
    logic               start_accept;
    logic               compare;
    logic               mismatch;
    logic [VEC_W-1:0]   stim;

    assign in_run       = (state_reg == RUN);
    assign start_accept = (state_reg == IDLE) && start_in;
    assign stim         = in_run ? vec_idx_reg : '0;
    assign mismatch     = {X_in, Y_in, Z_in} != exp_xyz(stim[2], stim[1], stim[0]);

    abc_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!in_run),
        .enable   (in_run),
        .terminal (compare)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_in) state_next = RUN;
            RUN:     if (compare && (vec_idx_reg == LAST_VEC)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx_reg   <= '0;
            err_count_reg <= '0;
        end else if (start_accept) begin
            vec_idx_reg   <= '0;
            err_count_reg <= '0;
        end else if (compare) begin
            // Wraps to 0 after vector 7, so IDLE/DONE report index 0.
            vec_idx_reg <= vec_idx_reg + 1'b1;
            if (mismatch && (err_count_reg != ERR_MAX)) begin
                err_count_reg <= err_count_reg + 1'b1;
            end
        end
    end

`ifdef ABC_SEQ_FAIL_CAPTURE_EN
    logic       first_fail_vld_reg;
    logic [5:0] first_fail_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld_reg <= 1'b0;
            first_fail_reg     <= '0;
        end else if (start_accept) begin
            first_fail_vld_reg <= 1'b0;
            first_fail_reg     <= '0;
        end else if (compare && mismatch && !first_fail_vld_reg) begin
            first_fail_vld_reg <= 1'b1;
            first_fail_reg     <= {vec_idx_reg, X_in, Y_in, Z_in};
        end
    end

    assign first_fail_vld_out = first_fail_vld_reg;
    assign first_fail_out     = first_fail_reg;
`endif

    assign A_out         = stim[2];
    assign B_out         = stim[1];
    assign C_out         = stim[0];
    assign vec_idx_out   = vec_idx_reg;
    assign busy_out      = in_run;
    assign done_out      = (state_reg == DONE);
    assign err_count_out = err_count_reg;

endmodule
